multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multi-cycle RV32I control sequencer; successor to the single-cycle opcode decoder.
- Sequences fetch, decode, execute, memory and writeback over several clocks for a shared-memory datapath.
- Adds a memory request/ready handshake, a bus timeout, illegal-opcode trapping, optional U-type support and run/halt control.
- Keeps the decoder's ALUSrc/ALUOp encodings: ALUOp 000=add, 001=branch compare, 010=R-type, 011=I-type; ALUSrc 00=reg, 01=imm, 10=PC/upper-imm.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting for mem_ready before a bus-error trap; 0 disables the timeout.
- ENABLE_UTYPE, 1, 1 decodes LUI (0110111) and AUIPC (0010111); 0 traps them as illegal.
- TMO_W, 5, timeout counter width; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; sampled only at instruction boundaries.
- opcode  in  7  instruction[6:0] from memory read data; valid in the fetch completion cycle.
- mem_ready  in  1  memory completes the current request this cycle.
- branch_taken  in  1  ALU compare result; valid in BRANCH.
- mem_req  out  1  memory request; held until mem_ready.
- IorD  out  1  memory address select: 0=PC, 1=ALU result.
- MemRead, MemWrite, RegWrite, MemToReg, Branch, IRWrite, PCWrite  out  1 each  datapath enables.
- ALUSrc  out  2  ALU operand B select, encoding as in Overview.
- ALUOp  out  3  ALU operation, encoding as in Overview.
- PCSrc  out  2  next-PC select: 00=PC+4, 01=PC+imm, 10=ALU (JALR), 11=trap vector.
- trap  out  1  one-cycle trap pulse.
- trap_cause  out  2  01=illegal opcode, 10=bus timeout; held until the next trap.
- retire  out  1  one-cycle pulse when an instruction completes.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, latched opcode=0, timeout counter=0, trap_cause=00. All outputs decode to 0.
- Outputs are combinational from state, latched opcode and inputs. Any output not listed for a state is 0.
- IDLE: all outputs 0. en=1 -> FETCH.
- FETCH: mem_req=1, MemRead=1, IorD=0.
  - When mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=00; latch opcode; next state DECODE.
- DECODE: one cycle, no enables. Next state by latched opcode:
  - 0110011 or 0010011 -> EXEC_ALU.
  - 0000011 or 0100011 -> EXEC_ADDR.
  - 1100011 -> BRANCH.
  - 1101111 or 1100111 -> JUMP.
  - 0110111 or 0010111 -> EXEC_ALU if ENABLE_UTYPE=1, otherwise TRAP with cause 01.
  - Any other opcode -> TRAP with cause 01.
- EXEC_ALU: R-type: ALUSrc=00, ALUOp=010. I-type: ALUSrc=01, ALUOp=011. LUI/AUIPC: ALUSrc=10, ALUOp=000. Next state WB_ALU.
- WB_ALU: RegWrite=1, MemToReg=0, retire=1.
- EXEC_ADDR: ALUSrc=01, ALUOp=000. Next state MEM.
- MEM: mem_req=1, IorD=1; MemRead=1 for load, MemWrite=1 for store.
  - On mem_ready: load -> WB_MEM; store -> retire=1, boundary.
- WB_MEM: RegWrite=1, MemToReg=1, retire=1.
- BRANCH: Branch=1, ALUOp=001, PCSrc=01, PCWrite=branch_taken, retire=1.
- JUMP: RegWrite=1, PCWrite=1, retire=1.
  - JAL: ALUSrc=10, PCSrc=01.
  - JALR: ALUSrc=01, PCSrc=10.
- TRAP: trap=1, PCWrite=1, PCSrc=11, retire=0; trap_cause is updated on entry.
- Boundary (end of WB_ALU, WB_MEM, store MEM, BRANCH, JUMP, TRAP): next state FETCH if en=1, else IDLE. Dropping en mid-instruction never aborts the instruction.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle there with mem_ready=0.
  - When MEM_TIMEOUT != 0 and the count reaches MEM_TIMEOUT-1 with mem_ready still 0, next state is TRAP with cause 10 and mem_req drops.
  - If mem_ready=1 in the same cycle the count reaches MEM_TIMEOUT-1, mem_ready wins.
- mem_ready outside FETCH/MEM is ignored.
- Reset asserted mid-transfer: mem_req drops immediately, with no retire or trap.

Test Plan:
- Reset, en=1, opcode=0110011, mem_ready high one cycle after each request -> states IDLE, FETCH(2 cycles), DECODE, EXEC_ALU(ALUOp=010), WB_ALU(RegWrite=1, retire=1), FETCH; 6 cycles from first mem_req.
- Load 0000011, MEM wait 3 cycles -> MemRead=1 and IorD=1 held 4 cycles; WB_MEM has MemToReg=1. Store 0100011 -> MemWrite=1, no RegWrite, retire on the MEM ready cycle.
- BRANCH with branch_taken=0 -> PCWrite=0. BRANCH with branch_taken=1 -> PCWrite=1, PCSrc=01. JALR -> PCSrc=10, RegWrite=1.
- opcode=0000000 -> TRAP: trap=1 one cycle, trap_cause=01, PCSrc=11. With ENABLE_UTYPE=0, opcode 0110111 -> same response.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP on the 5th cycle, cause=10. mem_ready=1 in the 4th cycle -> normal DECODE, no trap.
- en dropped during EXEC_ADDR -> the load completes through WB_MEM, then IDLE. rst_n pulsed low during MEM wait -> mem_req=0 immediately, state=IDLE.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control sequencer for a shared-memory datapath.
// Walks fetch/decode/execute/memory/writeback over several clocks, with a
// memory request/ready handshake, bus timeout, illegal-opcode trap,
// optional U-type decode and run/halt control at instruction boundaries.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int ENABLE_UTYPE = 1,
    parameter int TMO_W        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic       Branch,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] ALUSrc,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic       retire,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        s_idle      = 4'd0,
        s_fetch     = 4'd1,
        s_decode    = 4'd2,
        s_exec_alu  = 4'd3,
        s_wb_alu    = 4'd4,
        s_exec_addr = 4'd5,
        s_mem       = 4'd6,
        s_wb_mem    = 4'd7,
        s_branch    = 4'd8,
        s_jump      = 4'd9,
        s_trap      = 4'd10
    } state_t;

    localparam logic [6:0] op_rtype = 7'b0110011;
    localparam logic [6:0] op_itype = 7'b0010011;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_br    = 7'b1100011;
    localparam logic [6:0] op_jal   = 7'b1101111;
    localparam logic [6:0] op_jalr  = 7'b1100111;
    localparam logic [6:0] op_lui   = 7'b0110111;
    localparam logic [6:0] op_auipc = 7'b0010111;

    localparam logic [TMO_W-1:0] tmo_last = TMO_W'(MEM_TIMEOUT - 1);

    state_t           state_q, next_state;
    logic [6:0]       op_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic [1:0]       cause_nxt;
    logic             timeout_hit;
    logic             wait_state;
    logic             entering_wait;

    assign state         = state_q;
    assign wait_state    = (state_q == s_fetch) || (state_q == s_mem);
    assign entering_wait = ((next_state == s_fetch) || (next_state == s_mem)) &&
                           (next_state != state_q);
    assign timeout_hit   = (MEM_TIMEOUT != 0) && (tmo_cnt == tmo_last) && !mem_ready;

    // State, latched opcode, bus-wait counter and sticky trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= s_idle;
            op_q       <= '0;
            tmo_cnt    <= '0;
            trap_cause <= '0;
        end else begin
            state_q    <= next_state;
            trap_cause <= cause_nxt;
            if (state_q == s_fetch && mem_ready)
                op_q <= opcode;
            if (entering_wait)
                tmo_cnt <= '0;
            else if (wait_state && !mem_ready)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Next-state and datapath controls from state, latched opcode and inputs.
    always_comb begin
        next_state = state_q;
        cause_nxt  = trap_cause;
        mem_req    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        MemToReg   = 1'b0;
        Branch     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        ALUSrc     = 2'b00;
        ALUOp      = 3'b000;
        PCSrc      = 2'b00;
        trap       = 1'b0;
        retire     = 1'b0;
        case (state_q)
            s_idle: begin
                if (en) next_state = s_fetch;
            end
            s_fetch: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = s_decode;
                end else if (timeout_hit) begin
                    next_state = s_trap;
                    cause_nxt  = 2'b10;
                end
            end
            s_decode: begin
                case (op_q)
                    op_rtype, op_itype: next_state = s_exec_alu;
                    op_load, op_store:  next_state = s_exec_addr;
                    op_br:              next_state = s_branch;
                    op_jal, op_jalr:    next_state = s_jump;
                    op_lui, op_auipc: begin
                        if (ENABLE_UTYPE != 0) begin
                            next_state = s_exec_alu;
                        end else begin
                            next_state = s_trap;
                            cause_nxt  = 2'b01;
                        end
                    end
                    default: begin
                        next_state = s_trap;
                        cause_nxt  = 2'b01;
                    end
                endcase
            end
            s_exec_alu: begin
                if (op_q == op_rtype) begin
                    ALUSrc = 2'b00;
                    ALUOp  = 3'b010;
                end else if (op_q == op_itype) begin
                    ALUSrc = 2'b01;
                    ALUOp  = 3'b011;
                end else begin
                    ALUSrc = 2'b10;
                    ALUOp  = 3'b000;
                end
                next_state = s_wb_alu;
            end
            s_wb_alu: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = en ? s_fetch : s_idle;
            end
            s_exec_addr: begin
                ALUSrc     = 2'b01;
                next_state = s_mem;
            end
            s_mem: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemRead  = (op_q == op_load);
                MemWrite = (op_q != op_load);
                if (mem_ready) begin
                    if (op_q == op_load) begin
                        next_state = s_wb_mem;
                    end else begin
                        retire     = 1'b1;
                        next_state = en ? s_fetch : s_idle;
                    end
                end else if (timeout_hit) begin
                    next_state = s_trap;
                    cause_nxt  = 2'b10;
                end
            end
            s_wb_mem: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                retire     = 1'b1;
                next_state = en ? s_fetch : s_idle;
            end
            s_branch: begin
                Branch     = 1'b1;
                ALUOp      = 3'b001;
                PCSrc      = 2'b01;
                PCWrite    = branch_taken;
                retire     = 1'b1;
                next_state = en ? s_fetch : s_idle;
            end
            s_jump: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                retire   = 1'b1;
                if (op_q == op_jalr) begin
                    ALUSrc = 2'b01;
                    PCSrc  = 2'b10;
                end else begin
                    ALUSrc = 2'b10;
                    PCSrc  = 2'b01;
                end
                next_state = en ? s_fetch : s_idle;
            end
            s_trap: begin
                trap       = 1'b1;
                PCWrite    = 1'b1;
                PCSrc      = 2'b11;
                next_state = en ? s_fetch : s_idle;
            end
            default: next_state = s_idle;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a vector table for the
// non-memory instruction classes plus hand sequences for memory waits,
// timeout, run/halt, reset mid-transfer and disabled U-type decode.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;

    logic       mem_req, IorD, MemRead, MemWrite, RegWrite, MemToReg, Branch;
    logic       IRWrite, PCWrite, trap, retire;
    logic [1:0] ALUSrc, PCSrc, trap_cause;
    logic [2:0] ALUOp;
    logic [3:0] state;

    logic       u_mem_req, u_IorD, u_MemRead, u_MemWrite, u_RegWrite, u_MemToReg, u_Branch;
    logic       u_IRWrite, u_PCWrite, u_trap, u_retire;
    logic [1:0] u_ALUSrc, u_PCSrc, u_trap_cause;
    logic [2:0] u_ALUOp;
    logic [3:0] u_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.MEM_TIMEOUT(4), .ENABLE_UTYPE(1), .TMO_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .MemToReg(MemToReg), .Branch(Branch),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .trap(trap), .trap_cause(trap_cause), .retire(retire), .state(state)
    );

    multicycle_control_unit #(.MEM_TIMEOUT(16), .ENABLE_UTYPE(0), .TMO_W(5)) dut_nou (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(u_mem_req), .IorD(u_IorD), .MemRead(u_MemRead),
        .MemWrite(u_MemWrite), .RegWrite(u_RegWrite), .MemToReg(u_MemToReg), .Branch(u_Branch),
        .IRWrite(u_IRWrite), .PCWrite(u_PCWrite), .ALUSrc(u_ALUSrc), .ALUOp(u_ALUOp),
        .PCSrc(u_PCSrc), .trap(u_trap), .trap_cause(u_trap_cause), .retire(u_retire),
        .state(u_state)
    );

    // {mem_req,IorD,MemRead,MemWrite,RegWrite,MemToReg,Branch,IRWrite,PCWrite,ALUSrc,ALUOp,PCSrc,trap,retire}
    function automatic logic [17:0] mk(input logic rq, input logic iord, input logic mr,
                                       input logic mw, input logic rw, input logic m2r,
                                       input logic br, input logic irw, input logic pcw,
                                       input logic [1:0] asrc, input logic [2:0] aop,
                                       input logic [1:0] psrc, input logic tr, input logic ret);
        return {rq, iord, mr, mw, rw, m2r, br, irw, pcw, asrc, aop, psrc, tr, ret};
    endfunction

    function automatic logic [17:0] outs();
        return {mem_req, IorD, MemRead, MemWrite, RegWrite, MemToReg, Branch, IRWrite,
                PCWrite, ALUSrc, ALUOp, PCSrc, trap, retire};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_cycle(input string name, input logic [3:0] st, input logic [17:0] o);
        check({name, ".state"}, 32'(state), 32'(st));
        check({name, ".outs"}, 32'(outs()), 32'(o));
    endtask

    // Advance one clock; inputs change just after the edge, checks a bit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      name;
        logic [6:0] op;
        logic       br;
        logic [3:0] st1;
        logic [17:0] o1;
        logic [3:0] st2;   // 1 means the instruction ends after st1
        logic [17:0] o2;
        logic [1:0] cause;
    } vec_t;

    vec_t tbl[10];

    logic [17:0] f_rdy, f_wait, wb_alu;

    initial begin
        f_rdy  = mk(1,0,1,0,0,0,0,1,1,2'd0,3'd0,2'd0,0,0);
        f_wait = mk(1,0,1,0,0,0,0,0,0,2'd0,3'd0,2'd0,0,0);
        wb_alu = mk(0,0,0,0,1,0,0,0,0,2'd0,3'd0,2'd0,0,1);

        tbl[0] = '{"rtype", 7'b0110011, 0, 4'd3, mk(0,0,0,0,0,0,0,0,0,2'd0,3'd2,2'd0,0,0), 4'd4, wb_alu, 2'd0};
        tbl[1] = '{"itype", 7'b0010011, 0, 4'd3, mk(0,0,0,0,0,0,0,0,0,2'd1,3'd3,2'd0,0,0), 4'd4, wb_alu, 2'd0};
        tbl[2] = '{"lui",   7'b0110111, 0, 4'd3, mk(0,0,0,0,0,0,0,0,0,2'd2,3'd0,2'd0,0,0), 4'd4, wb_alu, 2'd0};
        tbl[3] = '{"auipc", 7'b0010111, 0, 4'd3, mk(0,0,0,0,0,0,0,0,0,2'd2,3'd0,2'd0,0,0), 4'd4, wb_alu, 2'd0};
        tbl[4] = '{"br_nt", 7'b1100011, 0, 4'd8, mk(0,0,0,0,0,0,1,0,0,2'd0,3'd1,2'd1,0,1), 4'd1, '0, 2'd0};
        tbl[5] = '{"br_t",  7'b1100011, 1, 4'd8, mk(0,0,0,0,0,0,1,0,1,2'd0,3'd1,2'd1,0,1), 4'd1, '0, 2'd0};
        tbl[6] = '{"jal",   7'b1101111, 0, 4'd9, mk(0,0,0,0,1,0,0,0,1,2'd2,3'd0,2'd1,0,1), 4'd1, '0, 2'd0};
        tbl[7] = '{"jalr",  7'b1100111, 0, 4'd9, mk(0,0,0,0,1,0,0,0,1,2'd1,3'd0,2'd2,0,1), 4'd1, '0, 2'd0};
        tbl[8] = '{"ill0",  7'b0000000, 0, 4'd10, mk(0,0,0,0,0,0,0,0,1,2'd0,3'd0,2'd3,1,0), 4'd1, '0, 2'd1};
        tbl[9] = '{"ill_sys", 7'b1110011, 0, 4'd10, mk(0,0,0,0,0,0,0,0,1,2'd0,3'd0,2'd3,1,0), 4'd1, '0, 2'd1};

        // Reset state
        rst_n = 1'b0; en = 1'b0; opcode = '0; mem_ready = 1'b0; branch_taken = 1'b0;
        #2;
        check_cycle("reset", 4'd0, '0);
        check("reset.cause", 32'(trap_cause), 32'd0);
        tick();
        rst_n = 1'b1;
        en = 1'b1;
        #1;
        check_cycle("idle_en", 4'd0, '0);

        // R-type with one wait cycle in fetch: 6 cycles from first mem_req
        tick(); #1; check_cycle("r.fetch_wait", 4'd1, f_wait);
        tick(); opcode = 7'b0110011; mem_ready = 1'b1; #1; check_cycle("r.fetch_rdy", 4'd1, f_rdy);
        tick(); mem_ready = 1'b0; opcode = '0; #1; check_cycle("r.decode", 4'd2, '0);
        tick(); #1; check_cycle("r.exec", 4'd3, mk(0,0,0,0,0,0,0,0,0,2'd0,3'd2,2'd0,0,0));
        tick(); #1; check_cycle("r.wb", 4'd4, wb_alu);
        tick(); #1; check("r.back_fetch", 32'(state), 32'd1);

        // Table: each vector starts in a fresh FETCH with mem_ready high
        for (int i = 0; i < 10; i++) begin
            opcode = tbl[i].op; mem_ready = 1'b1; branch_taken = tbl[i].br;
            #1; check_cycle({tbl[i].name, ".fetch"}, 4'd1, f_rdy);
            tick(); mem_ready = 1'b0; opcode = 7'h55; #1;
            check_cycle({tbl[i].name, ".decode"}, 4'd2, '0);
            tick(); #1;
            check_cycle({tbl[i].name, ".s1"}, tbl[i].st1, tbl[i].o1);
            if (tbl[i].st1 == 4'd10)
                check({tbl[i].name, ".cause"}, 32'(trap_cause), 32'(tbl[i].cause));
            tick(); #1;
            if (tbl[i].st2 != 4'd1) begin
                check_cycle({tbl[i].name, ".s2"}, tbl[i].st2, tbl[i].o2);
                tick(); #1;
            end
            check({tbl[i].name, ".next"}, 32'(state), 32'd1);
            check({tbl[i].name, ".trap_gone"}, 32'(trap), 32'd0);
        end

        // Load with three MEM wait cycles; ready on the fourth (count at limit)
        opcode = 7'b0000011; mem_ready = 1'b1; branch_taken = 1'b0;
        #1; check_cycle("ld.fetch", 4'd1, f_rdy);
        tick(); mem_ready = 1'b0; #1; check_cycle("ld.decode", 4'd2, '0);
        tick(); #1; check_cycle("ld.addr", 4'd5, mk(0,0,0,0,0,0,0,0,0,2'd1,3'd0,2'd0,0,0));
        for (int c = 0; c < 4; c++) begin
            tick(); mem_ready = (c == 3); #1;
            check_cycle($sformatf("ld.mem%0d", c), 4'd6, mk(1,1,1,0,0,0,0,0,0,2'd0,3'd0,2'd0,0,0));
        end
        tick(); mem_ready = 1'b0; #1; check_cycle("ld.wb", 4'd7, mk(0,0,0,0,1,1,0,0,0,2'd0,3'd0,2'd0,0,1));
        tick(); #1; check("ld.next", 32'(state), 32'd1);

        // Store retiring in the MEM ready cycle
        opcode = 7'b0100011; mem_ready = 1'b1;
        #1; check_cycle("st.fetch", 4'd1, f_rdy);
        tick(); mem_ready = 1'b0; #1; check_cycle("st.decode", 4'd2, '0);
        tick(); #1; check_cycle("st.addr", 4'd5, mk(0,0,0,0,0,0,0,0,0,2'd1,3'd0,2'd0,0,0));
        tick(); mem_ready = 1'b1; #1; check_cycle("st.mem", 4'd6, mk(1,1,0,1,0,0,0,0,0,2'd0,3'd0,2'd0,0,1));
        tick(); mem_ready = 1'b0; #1; check("st.next", 32'(state), 32'd1);

        // Fetch timeout: four cycles without ready, trap on the fifth
        for (int c = 0; c < 4; c++) begin
            check($sformatf("tmo.fetch%0d", c), 32'(state), 32'd1);
            tick();
        end
        #1;
        check_cycle("tmo.trap", 4'd10, mk(0,0,0,0,0,0,0,0,1,2'd0,3'd0,2'd3,1,0));
        check("tmo.cause", 32'(trap_cause), 32'd2);
        tick(); #1; check("tmo.next", 32'(state), 32'd1);

        // Ready in the fourth cycle wins over the timeout
        opcode = 7'b0110011;
        for (int c = 0; c < 3; c++) tick();
        mem_ready = 1'b1; #1;
        check_cycle("tmo_edge.fetch", 4'd1, f_rdy);
        tick(); mem_ready = 1'b0; #1;
        check_cycle("tmo_edge.decode", 4'd2, '0);
        check("tmo_edge.cause_held", 32'(trap_cause), 32'd2);
        tick(); tick(); tick(); #1;
        check("tmo_edge.next", 32'(state), 32'd1);

        // en dropped during EXEC_ADDR: load still completes, then IDLE
        opcode = 7'b0000011; mem_ready = 1'b1;
        tick(); mem_ready = 1'b0;
        tick(); en = 1'b0; #1; check("halt.addr", 32'(state), 32'd5);
        tick(); mem_ready = 1'b1; #1; check("halt.mem", 32'(state), 32'd6);
        tick(); mem_ready = 1'b0; #1; check_cycle("halt.wb", 4'd7, mk(0,0,0,0,1,1,0,0,0,2'd0,3'd0,2'd0,0,1));
        tick(); #1; check_cycle("halt.idle", 4'd0, '0);
        tick(); #1; check("halt.stay", 32'(state), 32'd0);

        // Reset pulsed during a MEM wait
        en = 1'b1;
        tick(); mem_ready = 1'b1;
        tick(); mem_ready = 1'b0;
        tick(); tick(); tick(); #1;
        check("rst.mem_req_before", 32'(mem_req), 32'd1);
        check("rst.state_before", 32'(state), 32'd6);
        rst_n = 1'b0; #1;
        check_cycle("rst.mid", 4'd0, '0);
        check("rst.cause", 32'(trap_cause), 32'd0);

        // U-type disabled: LUI traps as illegal on the second instance
        tick(); rst_n = 1'b1; opcode = 7'b0110111;
        tick(); mem_ready = 1'b1; #1;
        check("nou.fetch", 32'(u_state), 32'd1);
        tick(); mem_ready = 1'b0; #1;
        check("nou.decode", 32'(u_state), 32'd2);
        tick(); #1;
        check("nou.state", 32'(u_state), 32'd10);
        check("nou.trap", 32'({u_trap, u_PCSrc, u_retire}), 32'b1110);
        check("nou.cause", 32'(u_trap_cause), 32'd1);
        check("nou.main_exec", 32'(state), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
